// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - request/config handshake between a byte source and uart_tx_framer
interface uart_tx_framer_if;
  logic       send;
  logic [7:0] data_in;
  logic       bd_rate;
  logic       d_num;
  logic       s_num;
  logic       par;
  logic       tx_ready;
  logic       tx_done;

  modport master (
    output send, data_in, bd_rate, d_num, s_num, par,
    input  tx_ready, tx_done
  );

  modport slave (
    input  send, data_in, bd_rate, d_num, s_num, par,
    output tx_ready, tx_done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with internal baud counter
// UART_TX_ODD_PARITY_EN selects odd parity; default build sends even parity.
module uart_tx_framer #(
  parameter int DIV_SLOW = 16,
  parameter int DIV_FAST = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_framer_if.slave  bus,
  output logic             TX_out
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            stop_q, stop_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            load;

  logic [7:0]      data_q;
  logic            bd_rate_q, d_num_q, s_num_q, par_q;

  logic [CW-1:0]   div_last;
  logic            bit_end;
  logic [2:0]      idx_last;
  logic [2:0]      idx_inc;
  logic [7:0]      data_mask;
  logic            par_bit;

  // Frame timing comes only from the shadow copy taken at acceptance.
  assign div_last  = bd_rate_q ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
  assign bit_end   = (cnt_q == div_last);
  assign idx_last  = d_num_q ? 3'd7 : 3'd6;
  assign idx_inc   = idx_q + 3'd1;
  assign data_mask = d_num_q ? data_q : {1'b0, data_q[6:0]};

`ifdef UART_TX_ODD_PARITY_EN
  assign par_bit = ~(^data_mask);
`else
  assign par_bit = ^data_mask;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      data_q    <= 8'h00;
      bd_rate_q <= 1'b0;
      d_num_q   <= 1'b0;
      s_num_q   <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      if (load) begin
        data_q    <= bus.data_in;
        bd_rate_q <= bus.bd_rate;
        d_num_q   <= bus.d_num;
        s_num_q   <= bus.s_num;
        par_q     <= bus.par;
      end
    end
  end

  // tx_d is the line level for the state being entered, so TX_out stays a flop output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.send) begin
          load    = 1'b1;
          state_d = S_START;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == idx_last) begin
            stop_d = 1'b0;
            if (par_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_inc;
            tx_d  = data_q[idx_inc];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == s_num_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign TX_out       = tx_q;
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  localparam int DIV_SLOW = 16;
  localparam int DIV_FAST = 4;
`ifdef UART_TX_ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_out;

  uart_tx_framer_if bus();

  uart_tx_framer #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .TX_out (tx_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic cap[$];
  int   busy_cnt;

  typedef struct {
    logic       bd;
    logic       dn;
    logic       sn;
    logic       pr;
    logic [7:0] data;
    int         exp_cycles;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic bd, input logic dn, input logic sn, input logic pr,
                             input logic [7:0] d, input bit keep_send);
    check("ready_before_send", bus.tx_ready, 1);
    bus.bd_rate = bd;
    bus.d_num   = dn;
    bus.s_num   = sn;
    bus.par     = pr;
    bus.data_in = d;
    bus.send    = 1'b1;
    step();
    if (!keep_send) bus.send = 1'b0;
  endtask

  // Entered on the first cycle after the accept edge; leaves one cycle after tx_done.
  task automatic sample_frame(input logic bd, input logic dn, input logic sn, input logic pr,
                              input logic [7:0] d, input bit disturb, input bit hold_next,
                              input logic [7:0] next_d);
    logic bits[$];
    logic exp_q[$];
    int   div, n, ones, len, bad_w, bad_r, bad_d;
    div  = bd ? DIV_FAST : DIV_SLOW;
    n    = dn ? 8 : 7;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pr) bits.push_back(logic'(ones % 2 == 1) ^ ODD);
    for (int s = 0; s < 1 + int'(sn); s++) bits.push_back(1'b1);
    foreach (bits[j])
      for (int c = 0; c < div; c++) exp_q.push_back(bits[j]);
    len = exp_q.size();

    cap.delete();
    busy_cnt = 0;
    bad_w = 0; bad_r = 0; bad_d = 0;
    for (int k = 0; k < len; k++) begin
      cap.push_back(tx_out);
      if (tx_out !== exp_q[k]) bad_w++;
      if (bus.tx_ready !== 1'b0) bad_r++;
      else busy_cnt++;
      if (bus.tx_done !== 1'b0) bad_d++;
      if (disturb && k == len / 2) begin
        bus.data_in = 8'($urandom);
        bus.d_num   = 1'($urandom_range(0, 1));
        bus.s_num   = 1'($urandom_range(0, 1));
        bus.par     = 1'($urandom_range(0, 1));
        bus.bd_rate = 1'($urandom_range(0, 1));
        bus.send    = 1'b1;
      end
      if (disturb && k == len / 2 + 1) bus.send = 1'b0;
      step();
    end
    if (bus.tx_done !== 1'b1 || bus.tx_ready !== 1'b1 || tx_out !== 1'b1) bad_d++;
    if (hold_next) bus.data_in = next_d;
    else bus.send = 1'b0;
    step();
    if (!hold_next && (bus.tx_done !== 1'b0 || tx_out !== 1'b1)) bad_d++;
    check("frame_wave_mismatches", bad_w, 0);
    check("frame_ready_mismatches", bad_r, 0);
    check("frame_done_mismatches", bad_d, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [9:0] pat;
    int         bad, pos;
    logic       rbd, rdn, rsn, rpr;
    logic [7:0] rd;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 40,  1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 192, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hC1, 40,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h7F, 44,  1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 144, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 48,  1'b0};

    bus.send = 1'b0; bus.data_in = 8'h00; bus.bd_rate = 1'b0;
    bus.d_num = 1'b0; bus.s_num = 1'b0; bus.par = 1'b0;
    step();
    step();
    check("reset_tx_out", tx_out, 1);
    check("reset_tx_ready", bus.tx_ready, 1);
    check("reset_tx_done", bus.tx_done, 0);
    rst = 1'b0;
    step();

    // Fast rate, 8N1, 0xA5 against a literal bit pattern.
    start_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    sample_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    pat = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int k = 0; k < 40; k++) if (cap[k] !== pat[k / 4]) bad++;
    check("a5_literal_wave", bad, 0);
    check("a5_busy_cycles", busy_cnt, 40);

    foreach (vecs[i]) begin
      start_frame(vecs[i].bd, vecs[i].dn, vecs[i].sn, vecs[i].pr, vecs[i].data, 1'b0);
      sample_frame(vecs[i].bd, vecs[i].dn, vecs[i].sn, vecs[i].pr, vecs[i].data, 1'b0, 1'b0, 8'h00);
      check("vec_busy_cycles", busy_cnt, vecs[i].exp_cycles);
      if (vecs[i].pr) begin
        pos = ((vecs[i].dn ? 9 : 8) * (vecs[i].bd ? DIV_FAST : DIV_SLOW))
              + (vecs[i].bd ? DIV_FAST : DIV_SLOW) / 2;
        check("vec_parity_bit", cap[pos], vecs[i].exp_par ^ ODD);
      end
    end

    // send held high: second frame must start right after the done cycle.
    start_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    sample_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
    bus.send = 1'b0;
    sample_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00);

    // Inputs and send toggled mid-frame.
    start_frame(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    sample_frame(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00);

    // Reset in the middle of the data bits of 0x55.
    start_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1;
    #1;
    check("midrst_tx_out", tx_out, 1);
    check("midrst_tx_ready", bus.tx_ready, 1);
    step();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (bus.tx_done !== 1'b0 || tx_out !== 1'b1) bad++;
      step();
    end
    check("midrst_no_done_idle_line", bad, 0);
    start_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    sample_frame(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00);

    for (int r = 0; r < 16; r++) begin
      rbd = 1'($urandom_range(0, 1));
      rdn = 1'($urandom_range(0, 1));
      rsn = 1'($urandom_range(0, 1));
      rpr = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      start_frame(rbd, rdn, rsn, rpr, rd, 1'b0);
      sample_frame(rbd, rdn, rsn, rpr, rd, bit'($urandom_range(0, 1)), 1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Single-clock UART transmitter that serialises one byte per request onto a line, using the same framing controls as the receive side: baud select, data-bit count, stop-bit count and parity enable.
- Drives the RX_IN line of the loopback block, either in a bench or board-to-board; it is the sending end of the link that the receive path consumes.
- Has an internal baud counter, so no external divided clock is needed.

Parameters:
- DIV_SLOW, 16, clk cycles per bit when bd_rate=0 (>=2)
- DIV_FAST, 4, clk cycles per bit when bd_rate=1 (>=2)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- bd_rate  input  1  0: DIV_SLOW cycles/bit; 1: DIV_FAST cycles/bit
- d_num  input  1  0: 7 data bits; 1: 8 data bits
- s_num  input  1  0: 1 stop bit; 1: 2 stop bits
- par  input  1  1: append parity bit after data; 0: no parity
- send  input  1  frame request, qualified by tx_ready
- data_in  input  8  byte to send, LSB first; bit 7 ignored when d_num=0
- TX_out  output  1  serial line, idle high
- tx_ready  output  1  high when idle and able to accept send
- tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, immediate): TX_out=1, tx_ready=1, tx_done=0, FSM=IDLE, baud counter=0, bit index=0.
- Accept rule: send=1 while tx_ready=1 at a clk edge. On that edge:
  - data_in, d_num, s_num, par and bd_rate are latched into shadow registers, and the frame uses only these.
  - tx_ready drops to 0.
  - FSM moves to START.
- send while tx_ready=0 is ignored; there is no queuing.
- Input changes after acceptance do not affect the frame in flight.
- States and bit timing:
  - IDLE: TX_out=1.
  - START: TX_out=0 for DIV cycles. TX_out goes low on the accept edge, so latency from send sample to start bit is 0 cycles after the edge.
  - DATA: bits 0..N-1 (N=7 or 8), each for DIV cycles, LSB first.
  - PARITY (only if par=1): one bit time. Value = XOR of the N transmitted data bits (even parity).
  - STOP: TX_out=1 for 1 or 2 bit times.
- Baud counter: counts 0..DIV-1 and wraps. A bit ends when count==DIV-1. The bit index advances in DATA, and the stop counter advances in STOP.
- Frame length = (1+N+P+S) x DIV cycles, where P=par and S=1+s_num.
- End of frame, on the edge ending the last stop bit:
  - FSM goes to IDLE.
  - tx_ready goes to 1.
  - tx_done pulses for exactly that one following cycle.
- Back-to-back frames: send held high causes re-acceptance on the first cycle tx_ready=1, so the next start bit follows the last stop bit with no gap.
- Reset mid-frame: TX_out returns high immediately and the partial frame is abandoned. No tx_done pulse is produced.
- TX_out is a registered output and glitch-free.

Optional Feature:
- Macro: UART_TX_ODD_PARITY_EN.
- Defined: the parity bit is the inverted XOR of the data bits (odd parity).
- Undefined: even parity as above.
- No port change in either case. The receiver must be built with the matching parity sense.

Test Plan:
- Reset, then bd_rate=1, d_num=1, s_num=0, par=0, data_in=0xA5, pulse send -> expected response:
  - TX_out: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - tx_ready low for 40 cycles.
  - tx_done pulses once at cycle 40.
- d_num=1, s_num=1, par=1, data_in=0xA5, bd_rate=0 -> expected response:
  - Parity bit is 0 (1 with UART_TX_ODD_PARITY_EN).
  - 12 bits x 16 = 192 cycles busy.
- d_num=0, par=1, data_in=0xC1 -> expected response:
  - Data bits are 1,0,0,0,0,0,1 (bit 7 not sent).
  - Parity is 0 (two ones).
  - Frame is 10 bits.
- send held high with data_in=0x00 then 0xFF -> expected response:
  - Second start bit begins the cycle after the first frame's stop bit ends, with no idle gap.
  - send pulses during a frame do not alter TX_out.
- Change data_in/d_num/bd_rate mid-frame -> the frame in flight is unchanged.
- Assert rst mid-DATA of 0x55 -> expected response:
  - TX_out=1 and tx_ready=1 within the same cycle.
  - No tx_done pulse.
  - The next send transmits a clean full frame.
